// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter_ctrl block.
// Prescaled tick source is selected by COUNTER_CTRL_PRESCALE_EN (see counter_ctrl.sv).
package counter_ctrl_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_PRESC_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/counter_ctrl_presc.sv
// Tick prescaler: one tick every load+1 enabled cycles, phase cleared by clr.
// Only compiled when COUNTER_CTRL_PRESCALE_EN is defined.
`ifdef COUNTER_CTRL_PRESCALE_EN
module counter_ctrl_presc
   import counter_ctrl_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] load,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt_q;
   logic [PRESC_W-1:0] cnt_d;

   // Phase only advances while enabled, so a pause freezes it mid-period.
   assign tick = en && (cnt_q == load);

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/counter_ctrl.sv
// Start/stop/pause terminal counter with one-shot and auto-reload modes.
// Define COUNTER_CTRL_PRESCALE_EN to divide the tick by presc+1; otherwise ticks every RUN cycle.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [WIDTH-1:0]   term,
   input  logic [PRESC_W-1:0] presc,
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               done
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   term_q, term_d;
   logic               mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               run_en;
   logic               idle_start;
   logic               tick;

   // A stop cycle in RUN must not tick, so stop wins over a coincident terminal tick.
   assign run_en     = (state_q == RUN) && !stop;
   assign idle_start = (state_q == IDLE) && start && !stop;

`ifdef COUNTER_CTRL_PRESCALE_EN
   logic [PRESC_W-1:0] presc_q, presc_d;

   assign presc_d = idle_start ? presc : presc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   counter_ctrl_presc #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (run_en),
      .clr  (idle_start),
      .load (presc_q),
      .tick (tick)
   );
`else
   logic presc_unused;

   assign presc_unused = ^presc;
   assign tick         = run_en;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      term_d  = term_q;
      mode_d  = mode_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (idle_start) begin
               state_d = RUN;
               count_d = '0;
               term_d  = term;
               mode_d  = mode;
            end
         end

         RUN: begin
            if (stop) begin
               state_d = PAUSE;
            end else if (tick) begin
               if (count_q == term_q) begin
                  done_d = 1'b1;
                  if (mode_q) begin
                     count_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end

         PAUSE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         term_q  <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl (default or COUNTER_CTRL_PRESCALE_EN build).
module tb_counter_ctrl;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 4;
`ifdef COUNTER_CTRL_PRESCALE_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               mode = 1'b0;
   logic [WIDTH-1:0]   term = '0;
   logic [PRESC_W-1:0] presc = '0;
   logic [WIDTH-1:0]   count;
   logic               busy;
   logic               done;

   int tests_run = 0;
   int fails = 0;

   counter_ctrl #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .term  (term),
      .presc (presc),
      .count (count),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [WIDTH-1:0] c, input logic b, input logic d);
      tests_run++;
      if ({count, busy, done} !== {c, b, d}) begin
         fails++;
         $display("FAIL %s: got count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
                  name, count, busy, done, c, b, d);
      end
   endtask

   task automatic launch(input logic m, input logic [WIDTH-1:0] t, input logic [PRESC_W-1:0] p);
      mode  = m;
      term  = t;
      presc = p;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      expect_out("reset_early", 8'd0, 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      expect_out("reset_held_with_start", 8'd0, 1'b0, 1'b0);
      start = 1'b0;
      #10;
      rst = 1'b0;
      #1;
      expect_out("reset_release", 8'd0, 1'b0, 1'b0);
      step();
      expect_out("reset_after_edge", 8'd0, 1'b0, 1'b0);
   endtask

   task automatic test_one_shot();
      launch(1'b0, 8'd3, '0);
      term = 8'd9;
      mode = 1'b1;
      expect_out("oneshot_entry", 8'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step();
         expect_out($sformatf("oneshot_tick%0d", i), WIDTH'(i), 1'b1, 1'b0);
      end
      step();
      expect_out("oneshot_done", 8'd3, 1'b0, 1'b1);
      step();
      expect_out("oneshot_idle_hold", 8'd3, 1'b0, 1'b0);
   endtask

   task automatic test_term_zero();
      launch(1'b0, 8'd0, '0);
      expect_out("term0_entry", 8'd0, 1'b1, 1'b0);
      step();
      expect_out("term0_done", 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_auto_reload();
      launch(1'b1, 8'd2, '0);
      expect_out("auto_entry", 8'd0, 1'b1, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         start = (k == 4);
         step();
         expect_out($sformatf("auto_tick%0d", k), WIDTH'(k % 3), 1'b1, (k % 3) == 0);
      end
      start = 1'b0;
      stop  = 1'b1;
      step();
      expect_out("auto_pause", 8'd0, 1'b1, 1'b0);
      step();
      stop = 1'b0;
      expect_out("auto_abort", 8'd0, 1'b0, 1'b0);
   endtask

   task automatic test_pause_resume();
      launch(1'b0, 8'd10, '0);
      repeat (5) step();
      expect_out("pause_pre", 8'd5, 1'b1, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      expect_out("pause_enter", 8'd5, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out($sformatf("pause_hold%0d", i), 8'd5, 1'b1, 1'b0);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      expect_out("pause_resume_edge", 8'd5, 1'b1, 1'b0);
      step();
      expect_out("pause_resume_tick", 8'd6, 1'b1, 1'b0);
      stop = 1'b1;
      step();
      step();
      stop = 1'b0;
      expect_out("pause_abort", 8'd6, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      launch(1'b0, 8'd20, '0);
      repeat (2) step();
      start = 1'b1;
      stop  = 1'b1;
      step();
      expect_out("both_in_run", 8'd2, 1'b1, 1'b0);
      step();
      expect_out("both_in_pause", 8'd2, 1'b0, 1'b0);
      step();
      start = 1'b0;
      stop  = 1'b0;
      expect_out("both_in_idle", 8'd2, 1'b0, 1'b0);
   endtask

   task automatic test_stop_on_terminal();
      launch(1'b0, 8'd2, '0);
      repeat (2) step();
      expect_out("stopterm_pre", 8'd2, 1'b1, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      expect_out("stopterm_pause", 8'd2, 1'b1, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      expect_out("stopterm_resume", 8'd2, 1'b1, 1'b0);
      step();
      expect_out("stopterm_done", 8'd2, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      launch(1'b1, 8'd20, '0);
      repeat (7) step();
      expect_out("midrst_pre", 8'd7, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      expect_out("midrst_immediate", 8'd0, 1'b0, 1'b0);
      #12;
      rst = 1'b0;
      step();
      expect_out("midrst_after", 8'd0, 1'b0, 1'b0);
      launch(1'b0, 8'd1, '0);
      expect_out("midrst_first_start", 8'd0, 1'b1, 1'b0);
      step();
      step();
      expect_out("midrst_first_done", 8'd1, 1'b0, 1'b1);
   endtask

   task automatic test_max_term();
      launch(1'b0, 8'd255, '0);
      repeat (128) step();
      expect_out("max_mid", 8'd128, 1'b1, 1'b0);
      repeat (127) step();
      expect_out("max_top", 8'd255, 1'b1, 1'b0);
      step();
      expect_out("max_done", 8'd255, 1'b0, 1'b1);
      step();
      expect_out("max_hold", 8'd255, 1'b0, 1'b0);
   endtask

   task automatic test_presc();
      launch(1'b0, 8'd1, 4'd3);
      presc = 4'd0;
      expect_out("presc_entry", 8'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 2 * DIV; c++) begin
         step();
         expect_out($sformatf("presc_cyc%0d", c), (c >= DIV) ? 8'd1 : 8'd0,
                    c < 2 * DIV, c == 2 * DIV);
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_term_zero();
      test_auto_reload();
      test_pause_resume();
      test_back_to_back();
      test_stop_on_terminal();
      test_mid_reset();
      test_max_term();
      test_presc();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
